// File: rtl/sevenseg_scan_decoder.sv
`default_nettype none
// ============================================================================
// Module   : sevenseg_scan_decoder
// Brief    : Recovers BCD digits, decimal points and glyph errors from the
//            scanned, multiplexed 4-digit 7-segment display bus.
// Revision : 1.0 - initial release
// ============================================================================
module sevenseg_scan_decoder #(
    parameter int SETTLE_CYCLES  = 16,
    parameter int TIMEOUT_CYCLES = 2**20,
    parameter int CNT_W          = 21
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [7:0]  seg_n_in,
    input  logic [3:0]  dig_in,
    output logic [15:0] digits,
    output logic [3:0]  dp,
    output logic [3:0]  err,
    output logic        frame_valid,
    output logic        stale
);

    localparam logic [CNT_W-1:0] c_settle_max   = CNT_W'(SETTLE_CYCLES);
    localparam logic [CNT_W-1:0] c_settle_last  = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_timeout_max  = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] c_timeout_last = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_cnt_one      = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_HOLD   = 2'd2
    } state_t;

    logic [7:0]       r_seg_meta, r_seg_s;
    logic [3:0]       r_dig_meta, r_dig_s;

    state_t           r_state, w_state_nxt;
    logic [3:0]       r_ref_dig, w_ref_dig_nxt;
    logic [7:0]       r_ref_seg, w_ref_seg_nxt;
    logic [CNT_W-1:0] r_settle_cnt, w_settle_nxt;
    logic             w_capture;
    logic             w_onehot;
    logic             w_changed;

    logic [3:0]       r_hold_val [0:3];
    logic [3:0]       r_hold_dp, r_hold_err;
    logic [3:0]       r_mask, w_mask_nxt;
    logic [15:0]      r_digits;
    logic [3:0]       r_dp, r_err;
    logic             r_fv, r_stale;
    logic [CNT_W-1:0] r_to_cnt;
    logic             w_frame_done;
    logic             w_to_hit;
    logic [4:0]       w_dec;

    // Returns {err, value}; blank lines decode to 0xF, anything unknown to 0xE.
    function automatic logic [4:0] f_decode(input logic [6:0] pat);
        case (pat)
            7'h3F:   f_decode = 5'h00;
            7'h06:   f_decode = 5'h01;
            7'h5B:   f_decode = 5'h02;
            7'h4F:   f_decode = 5'h03;
            7'h66:   f_decode = 5'h04;
            7'h6D:   f_decode = 5'h05;
            7'h7D:   f_decode = 5'h06;
            7'h07:   f_decode = 5'h07;
            7'h7F:   f_decode = 5'h08;
            7'h6F:   f_decode = 5'h09;
            7'h00:   f_decode = 5'h0F;
            default: f_decode = 5'h1E;
        endcase
    endfunction

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_seg_meta <= 8'd0;
            r_seg_s    <= 8'd0;
            r_dig_meta <= 4'd0;
            r_dig_s    <= 4'd0;
        end else begin
            r_seg_meta <= seg_n_in;
            r_seg_s    <= r_seg_meta;
            r_dig_meta <= dig_in;
            r_dig_s    <= r_dig_meta;
        end
    end

    assign w_onehot  = (r_dig_s != 4'd0) && ((r_dig_s & (r_dig_s - 4'd1)) == 4'd0);
    assign w_changed = (r_dig_s != r_ref_dig) || (r_seg_s != r_ref_seg);

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state      <= S_IDLE;
            r_ref_dig    <= 4'd0;
            r_ref_seg    <= 8'd0;
            r_settle_cnt <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_ref_dig    <= w_ref_dig_nxt;
            r_ref_seg    <= w_ref_seg_nxt;
            r_settle_cnt <= w_settle_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_ref_dig_nxt = r_ref_dig;
        w_ref_seg_nxt = r_ref_seg;
        w_settle_nxt  = r_settle_cnt;
        w_capture     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_onehot) begin
                    w_state_nxt   = S_SETTLE;
                    w_ref_dig_nxt = r_dig_s;
                    w_ref_seg_nxt = r_seg_s;
                    w_settle_nxt  = c_cnt_one;
                end
            end
            S_SETTLE: begin
                if (w_changed) begin
                    if (w_onehot) begin
                        w_ref_dig_nxt = r_dig_s;
                        w_ref_seg_nxt = r_seg_s;
                        w_settle_nxt  = c_cnt_one;
                    end else begin
                        w_state_nxt   = S_IDLE;
                    end
                end else if (r_settle_cnt == c_settle_last) begin
                    w_settle_nxt = c_settle_max;
                    w_capture    = 1'b1;
                    w_state_nxt  = S_HOLD;
                end else begin
                    w_settle_nxt = r_settle_cnt + c_cnt_one;
                end
            end
            S_HOLD: begin
                // Segment changes within the same enable period are ignored.
                if (r_dig_s != r_ref_dig) begin
                    if (w_onehot) begin
                        w_state_nxt   = S_SETTLE;
                        w_ref_dig_nxt = r_dig_s;
                        w_ref_seg_nxt = r_seg_s;
                        w_settle_nxt  = c_cnt_one;
                    end else begin
                        w_state_nxt   = S_IDLE;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_dec        = f_decode(~r_ref_seg[6:0]);
    assign w_frame_done = (r_mask == 4'hF);
    assign w_to_hit     = !w_capture && (r_to_cnt == c_timeout_last);

    always_comb begin
        w_mask_nxt = w_frame_done ? 4'd0 : r_mask;
        if (w_capture) begin
            w_mask_nxt = w_mask_nxt | r_ref_dig;
        end
        if (w_to_hit) begin
            w_mask_nxt = 4'd0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < 4; i++) begin
                r_hold_val[i] <= 4'd0;
            end
            r_hold_dp  <= 4'd0;
            r_hold_err <= 4'd0;
            r_mask     <= 4'd0;
            r_digits   <= 16'd0;
            r_dp       <= 4'd0;
            r_err      <= 4'd0;
            r_fv       <= 1'b0;
            r_stale    <= 1'b1;
            r_to_cnt   <= '0;
        end else begin
            r_fv   <= w_frame_done;
            r_mask <= w_mask_nxt;
            if (w_frame_done) begin
                r_digits <= {r_hold_val[0], r_hold_val[1], r_hold_val[2], r_hold_val[3]};
                r_dp     <= r_hold_dp;
                r_err    <= r_hold_err;
            end
            if (w_to_hit) begin
                r_stale <= 1'b1;
            end else if (w_frame_done) begin
                r_stale <= 1'b0;
            end
            if (w_capture) begin
                r_to_cnt <= '0;
            end else if (r_to_cnt != c_timeout_max) begin
                r_to_cnt <= r_to_cnt + c_cnt_one;
            end
            for (int i = 0; i < 4; i++) begin
                if (w_capture && r_ref_dig[i]) begin
                    r_hold_val[i] <= w_dec[3:0];
                    r_hold_dp[i]  <= ~r_ref_seg[7];
                    r_hold_err[i] <= w_dec[4];
                end
            end
        end
    end

    assign digits      = r_digits;
    assign dp          = r_dp;
    assign err         = r_err;
    assign frame_valid = r_fv;
    assign stale       = r_stale;

endmodule
`default_nettype wire

// File: tb/tb_sevenseg_scan_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_sevenseg_scan_decoder
// Brief    : Directed and randomized bench with a run-length reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sevenseg_scan_decoder;

    localparam int SETTLE = 16;
    localparam int TMO    = 3000;
    localparam int CW     = 12;

    logic        CLK = 1'b0;
    logic        RST;
    logic [7:0]  seg_n_in;
    logic [3:0]  dig_in;
    logic [15:0] digits;
    logic [3:0]  dp, err;
    logic        frame_valid, stale;

    always #5 CLK = ~CLK;

    sevenseg_scan_decoder #(
        .SETTLE_CYCLES (SETTLE),
        .TIMEOUT_CYCLES(TMO),
        .CNT_W         (CW)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .seg_n_in   (seg_n_in),
        .dig_in     (dig_in),
        .digits     (digits),
        .dp         (dp),
        .err        (err),
        .frame_valid(frame_valid),
        .stale      (stale)
    );

    int checks = 0;
    int errors = 0;
    bit armed  = 0;
    int fv_total = 0;
    int fv_n, fv_at, stale_at;

    logic [6:0] glyph [0:9] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [4:0] ref_decode(input logic [6:0] p);
        if (p == 7'h00) return 5'h0F;
        for (int k = 0; k < 10; k++) begin
            if (glyph[k] == p) return {1'b0, 4'(k)};
        end
        return 5'h1E;
    endfunction

    // Reference: count consecutive identical one-hot samples; the first run
    // reaching SETTLE within one enable period is a capture.
    logic [3:0]  m_s1d, m_s2d, m_pd;
    logic [7:0]  m_s1s, m_s2s, m_ps;
    int          m_run, m_since;
    bit          m_done;
    logic [3:0]  m_val [0:3];
    logic [3:0]  m_hdp, m_herr, m_mask;
    logic [15:0] e_digits;
    logic [3:0]  e_dp, e_err;
    logic        e_fv, e_stale;

    initial begin
        forever begin
            @(posedge CLK);
            if (RST === 1'b1) begin
                m_s1d = 0; m_s2d = 0; m_pd = 0; m_s1s = 0; m_s2s = 0; m_ps = 0;
                m_run = 0; m_since = 0; m_done = 0; m_mask = 0;
                m_hdp = 0; m_herr = 0;
                for (int i = 0; i < 4; i++) m_val[i] = 0;
                e_digits = 0; e_dp = 0; e_err = 0; e_fv = 0; e_stale = 1;
            end else begin
                logic [3:0] sd;
                logic [7:0] ss;
                logic [4:0] dec;
                bit cap;
                sd = m_s2d; ss = m_s2s; cap = 0;
                if ($countones(sd) == 1) begin
                    if (sd != m_pd) m_done = 0;
                    if (m_run > 0 && sd == m_pd && ss == m_ps) m_run = (m_run < SETTLE) ? m_run + 1 : SETTLE;
                    else m_run = 1;
                    if (m_run == SETTLE && !m_done) begin
                        cap = 1;
                        m_done = 1;
                    end
                end else begin
                    m_run = 0;
                    m_done = 0;
                end
                e_fv = 0;
                if (m_mask == 4'hF) begin
                    for (int i = 0; i < 4; i++) e_digits[15-4*i -: 4] = m_val[i];
                    e_dp = m_hdp; e_err = m_herr; e_fv = 1; e_stale = 0; m_mask = 0;
                end
                if (cap) begin
                    dec = ref_decode(~ss[6:0]);
                    for (int i = 0; i < 4; i++) begin
                        if (sd[i]) begin
                            m_val[i] = dec[3:0]; m_herr[i] = dec[4]; m_hdp[i] = ~ss[7]; m_mask[i] = 1;
                        end
                    end
                    m_since = 0;
                end else if (m_since < TMO) begin
                    m_since++;
                    if (m_since == TMO) begin
                        e_stale = 1;
                        m_mask = 0;
                    end
                end
                m_pd = sd; m_ps = ss;
                m_s2d = m_s1d; m_s2s = m_s1s;
                m_s1d = dig_in; m_s1s = seg_n_in;
            end
        end
    end

    initial begin
        forever begin
            @(negedge CLK);
            if (armed) begin
                chk("cyc_digits", digits, e_digits);
                chk("cyc_dp", dp, e_dp);
                chk("cyc_err", err, e_err);
                chk("cyc_frame_valid", frame_valid, e_fv);
                chk("cyc_stale", stale, e_stale);
            end
        end
    end

    task automatic show(input logic [3:0] d, input logic [7:0] s, input int n);
        dig_in = d; seg_n_in = s;
        fv_n = 0; fv_at = 0; stale_at = 0;
        for (int i = 1; i <= n; i++) begin
            @(negedge CLK);
            if (frame_valid === 1'b1) begin
                fv_n++; fv_total++;
                if (fv_at == 0) fv_at = i;
            end
            if (stale === 1'b1 && stale_at == 0) stale_at = i;
        end
    endtask

    task automatic scan(input logic [7:0] s0, input logic [7:0] s1,
                        input logic [7:0] s2, input logic [7:0] s3, input int n);
        show(4'b0001, s0, n);
        show(4'b0010, s1, n);
        show(4'b0100, s2, n);
        show(4'b1000, s3, n);
    endtask

    task automatic pulse_rst();
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int base;
        RST = 1'b1; dig_in = 4'd0; seg_n_in = 8'hFF;
        repeat (3) @(negedge CLK);
        armed = 1;
        chk("rst_digits", digits, 16'h0);
        chk("rst_stale", stale, 1);
        chk("rst_fv", frame_valid, 0);
        RST = 1'b0;

        // Scan "1234" twice
        base = fv_total;
        scan(~8'h06, ~8'h5B, ~8'h4F, ~8'h66, 1000);
        chk("t1_latency", fv_at, 19);
        scan(~8'h06, ~8'h5B, ~8'h4F, ~8'h66, 1000);
        chk("t1_fv_count", fv_total - base, 2);
        chk("t1_digits", digits, 16'h1234);
        chk("t1_dp_err", {dp, err}, 8'h00);
        chk("t1_stale", stale, 0);

        // Glitching digit 1 never settles; a later stable 8 completes the frame
        base = fv_total;
        show(4'b0001, ~8'h06, 100);
        for (int k = 0; k < 20; k++) show(4'b0010, (k % 2) ? ~8'h5B : ~8'h4F, 5);
        show(4'b0100, ~8'h4F, 100);
        show(4'b1000, ~8'h66, 100);
        chk("t2_no_fv", fv_total - base, 0);
        show(4'b0010, ~8'h7F, 100);
        chk("t2_fv", fv_n, 1);
        chk("t2_digits", digits, 16'h1834);

        // Decimal point, illegal pattern and blank
        scan(~8'hED, ~8'h3F, ~8'h49, 8'hFF, 100);
        chk("t3_digits", digits, 16'h50EF);
        chk("t3_dp", dp, 4'b0001);
        chk("t3_err", err, 4'b0100);

        // Overlapping enables capture nothing and keep the mask
        base = fv_total;
        show(4'b0001, ~8'h06, 100);
        show(4'b0011, ~8'h5B, 500);
        show(4'b0000, 8'hFF, 50);
        chk("t4_no_fv", fv_total - base, 0);
        show(4'b0010, ~8'h3F, 100);
        show(4'b0100, ~8'h4F, 100);
        show(4'b1000, ~8'h66, 100);
        chk("t4_fv", fv_total - base, 1);
        chk("t4_digits", digits, 16'h1034);

        // Timeout after a partial frame
        scan(~8'h06, ~8'h5B, ~8'h4F, ~8'h66, 100);
        show(4'b0001, ~8'h6D, 30);
        show(4'b0000, 8'hFF, TMO + 10);
        chk("t5_stale_latency", stale_at, TMO - 12);
        chk("t5_digits_kept", digits, 16'h1234);
        base = fv_total;
        show(4'b0010, ~8'h06, 100);
        show(4'b0100, ~8'h06, 100);
        show(4'b1000, ~8'h06, 100);
        chk("t5_mask_cleared", fv_total - base, 0);
        chk("t5_still_stale", stale, 1);
        show(4'b0001, ~8'h6D, 100);
        chk("t5_fv", fv_n, 1);
        chk("t5_digits", digits, 16'h5111);
        chk("t5_stale_clr", stale, 0);

        // Reset mid-frame discards partial data
        show(4'b0001, ~8'h06, 100);
        show(4'b0010, ~8'h5B, 100);
        show(4'b0000, 8'hFF, 5);
        pulse_rst();
        base = fv_total;
        scan(~8'h6F, ~8'h7F, ~8'h07, ~8'h7D, 100);
        chk("t6_fv", fv_total - base, 1);
        chk("t6_digits", digits, 16'h9876);

        // Randomized traffic
        for (int it = 0; it < 400; it++) begin
            logic [3:0] d;
            logic [7:0] s;
            int r, q;
            r = $urandom_range(0, 9);
            if (r < 7) d = 4'(1 << $urandom_range(0, 3));
            else if (r == 7) d = 4'd0;
            else d = 4'($urandom_range(0, 15));
            q = $urandom_range(0, 9);
            if (q < 7) s = ~{1'($urandom_range(0, 1)), glyph[$urandom_range(0, 9)]};
            else if (q == 7) s = 8'hFF;
            else s = 8'($urandom_range(0, 255));
            if (r == 9) begin
                for (int b = 0; b < 6; b++) show(d, 8'($urandom_range(0, 255)), $urandom_range(1, 8));
            end else begin
                show(d, s, $urandom_range(1, 60));
            end
            if ($urandom_range(0, 99) == 0) pulse_rst();
        end

        show(4'b0000, 8'hFF, 5);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
